rns2011_reverse_conv: RTL and testbench



---
 rtl/rns2011_reverse_conv.sv | 126 ++++++++++++
 tb/tb_rns2011_reverse_conv.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rns2011_reverse_conv.sv
// Residue-to-binary converter for the {2011, 2^11} moduli pair.
// Rebuilds X = k*2^RW + r2 from (X mod MOD, X mod 2^RW) by serial mixed radix.
module rns2011_reverse_conv #(
   parameter int MOD = 2011,
   parameter int INV = 924,
   parameter int RW  = 11,
   parameter int IW  = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [RW-1:0]   in_r1,
   input  logic [RW-1:0]   in_r2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*RW-1:0] out_x,
   output logic            out_err
);

   localparam int            CW = (IW > 1) ? $clog2(IW) : 1;
   localparam logic [RW:0]   M  = (RW+1)'(MOD);
   localparam logic [IW-1:0] IV = IW'(INV);

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      MUL,
      DONE
   } state_e;

   state_e        state_q, state_d;
   logic [RW-1:0] r1_q, r1_d;
   logic [RW-1:0] r2_q, r2_d;
   logic [RW-1:0] d_q, d_d;
   logic [RW-1:0] acc_q, acc_d;
   logic [CW-1:0] idx_q, idx_d;
   logic          err_q, err_d;

   logic [RW:0]   r2r, diff;
   logic [RW:0]   t0, t1, t2;
   logic          r1_bad;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         r1_q    <= '0;
         r2_q    <= '0;
         d_q     <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         d_q     <= d_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      r1_d      = r1_q;
      r2_d      = r2_q;
      d_d       = d_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      err_d     = err_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_x     = '0;
      out_err   = 1'b0;

      r1_bad = ({1'b0, r1_q} >= M);
      r2r    = {1'b0, r2_q};
      if (r2r >= M) r2r = r2r - M;
      diff = {1'b0, r1_q} - r2r;
      if ({1'b0, r1_q} < r2r) diff = diff + M;

      // one MSB-first step of acc = d*INV mod MOD
      t0 = {acc_q, 1'b0};
      t1 = (t0 >= M) ? t0 - M : t0;
      t2 = t1 + {1'b0, d_q};
      if (t2 >= M) t2 = t2 - M;
      if (!IV[idx_q]) t2 = t1;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               r1_d    = in_r1;
               r2_d    = in_r2;
               state_d = PREP;
            end
         end
         PREP: begin
            acc_d   = '0;
            err_d   = r1_bad;
            d_d     = diff[RW-1:0];
            idx_d   = CW'(IW-1);
            state_d = MUL;
            // bad r1: one zero-d drain step, so the flag lands a cycle later
            if (r1_bad) begin
               d_d   = '0;
               idx_d = '0;
            end
         end
         MUL: begin
            acc_d = t2[RW-1:0];
            idx_d = idx_q - CW'(1);
            if (idx_q == '0) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            out_err   = err_q;
            if (!err_q) out_x = {acc_q, r2_q};
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rns2011_reverse_conv.sv
// Scoreboard bench for rns2011_reverse_conv: directed cases,
// handshake/abort cases and a randomized X sweep.
module tb_rns2011_reverse_conv;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] in_r1;
   logic [10:0] in_r2;
   logic        out_valid;
   logic        out_ready;
   logic [21:0] out_x;
   logic        out_err;

   int checks = 0;
   int errors = 0;
   logic [22:0] sb_q[$];

   rns2011_reverse_conv dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_r1     (in_r1),
      .in_r2     (in_r2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // reference from the CRT formula, no shift-add
   function automatic logic [22:0] model(input int r1, input int r2);
      int k;
      if (r1 >= 2011) return {1'b1, 22'd0};
      k = (r1 - (r2 % 2011)) % 2011;
      if (k < 0) k += 2011;
      k = (k * 924) % 2011;
      return {1'b0, 22'(k * 2048 + r2)};
   endfunction

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", 1, 0);
         end else begin
            logic [22:0] e;
            e = sb_q.pop_front();
            chk("sb_err", int'(out_err), int'(e[22]));
            chk("sb_x", int'(out_x), int'(e[21:0]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int r1, input int r2,
                       input logic [22:0] exp,
                       output int lat);
      chk("pre_rdy", int'(in_ready), 1);
      in_valid = 1'b1;
      in_r1    = 11'(r1);
      in_r2    = 11'(r2);
      sb_q.push_back(exp);
      step();
      in_valid = 1'b0;
      chk("busy_rdy", int'(in_ready), 0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
   endtask

   task automatic finish_idle();
      int n;
      n = 0;
      while (!in_ready && n < 40) begin
         step();
         n++;
      end
      chk("idle_to", int'(in_ready), 1);
   endtask

   initial begin
      int lat;
      int x;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_r1     = '0;
      in_r2     = '0;
      out_ready = 1'b1;
      repeat (3) step();
      chk("rst_rdy", int'(in_ready), 1);
      chk("rst_ov", int'(out_valid), 0);
      chk("rst_x", int'(out_x), 0);
      chk("rst_err", int'(out_err), 0);
      rst = 1'b0;
      step();

      send(785, 576, {1'b0, 22'd123456}, lat);
      chk("lat_legal", lat, 11);
      step();
      chk("ov_1cyc", int'(out_valid), 0);
      chk("rdy_back", int'(in_ready), 1);

      send(2010, 2047, {1'b0, 22'd4118527}, lat);
      chk("lat_max", lat, 11);
      finish_idle();

      send(0, 0, {1'b0, 22'd0}, lat);
      finish_idle();
      send(1, 1, {1'b0, 22'd1}, lat);
      chk("lat_b2b", lat, 11);
      finish_idle();

      send(2011, 5, {1'b1, 22'd0}, lat);
      chk("lat_err", lat, 2);
      finish_idle();

      send(100, 100, model(100, 100), lat);
      finish_idle();

      // backpressure: result held, new input ignored
      out_ready = 1'b0;
      send(785, 576, {1'b0, 22'd123456}, lat);
      in_valid = 1'b1;
      in_r1    = 11'd3;
      in_r2    = 11'd4;
      for (int i = 0; i < 5; i++) begin
         chk("hold_ov", int'(out_valid), 1);
         chk("hold_x", int'(out_x), 123456);
         chk("hold_rdy", int'(in_ready), 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("bp_rdy", int'(in_ready), 1);
      chk("bp_ov", int'(out_valid), 0);

      // abort in the middle of the multiply
      in_valid = 1'b1;
      in_r1    = 11'd500;
      in_r2    = 11'd7;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_ov", int'(out_valid), 0);
      chk("abort_rdy", int'(in_ready), 1);
      for (int i = 0; i < 15; i++) begin
         if (out_valid) chk("abort_out", 1, 0);
         step();
      end

      for (int i = 0; i < 3000; i++) begin
         if (i == 0) x = 0;
         else if (i == 1) x = 4118527;
         else x = int'($urandom_range(4118527, 0));
         send(x % 2011, x % 2048, {1'b0, 22'(x)}, lat);
         if (lat != 11) chk("rnd_lat", lat, 11);
         finish_idle();
      end

      chk("sb_left", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
